// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant owners,
// default abort limit and the round-robin grant decision.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  localparam int DEFAULT_MAX_WAIT = 15;

  // On a tie the requester that was not served last wins.
  function automatic grant_e pick_grant(input logic if_req, input logic dm_req,
                                        input grant_e last);
    if (if_req && dm_req) return (last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    else if (dm_req)      return GNT_DATA;
    else                  return GNT_FETCH;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_wait_counter.sv
// Clear/enable wait counter; tc flags the MAX-th counted cycle so the owner
// can abort at the end of that cycle.
module wait_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX = DEFAULT_MAX_WAIT,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one multi-cycle memory port between fetch and data stages via an
// IDLE/BUSY/RESP sequencer, with pipeline stall generation and access abort.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  grant_e            owner_q, owner_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d, dm_rd_q, dm_rd_d;
  logic              tmo_q, tmo_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  wait_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if_rd_d = if_rd_q;
    dm_rd_d = dm_rd_q;
    tmo_d   = tmo_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          owner_d = pick_grant(if_req, dm_req, last_q);
          addr_d  = (owner_d == GNT_DATA) ? dm_addr : if_addr;
          we_d    = (owner_d == GNT_DATA) && dm_we;
          wdata_d = (owner_d == GNT_DATA) ? dm_wdata : '0;
          cnt_clr = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A late ack in the terminal cycle still wins over the abort.
        if (mem_ack) begin
          if (owner_q == GNT_DATA) dm_rd_d = mem_rdata;
          else                     if_rd_d = mem_rdata;
          state_d = ST_RESP;
        end else if (cnt_tc) begin
          tmo_d = 1'b1;
          if (owner_q == GNT_DATA) dm_rd_d = '0;
          else                     if_rd_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= GNT_FETCH;
      last_q  <= GNT_FETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      if_rd_q <= '0;
      dm_rd_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      if_rd_q <= if_rd_d;
      dm_rd_q <= dm_rd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_req     = (state_q == ST_BUSY);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_done     = (state_q == ST_RESP) && (owner_q == GNT_FETCH);
  assign dm_done     = (state_q == ST_RESP) && (owner_q == GNT_DATA);
  assign if_rdata    = if_rd_q;
  assign dm_rdata    = dm_rd_q;
  assign stall_if    = if_req && !if_done;
  assign stall_mem   = dm_req && !dm_done;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requesters push expected accesses,
// a memory responder picks latencies, and a monitor checks every cycle.
module tb_unified_mem_arbiter;
  localparam int AW = 32, DW = 32, MW = 15;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic if_done, dm_done, mem_req, mem_we, stall_if, stall_mem, timeout_err;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;

  int vectors = 0, errors = 0;
  int cyc = 0;
  int force_lat = -1;
  req_t if_q[$], dm_q[$];
  int lat_q[$];
  logic [31:0] mem_img[logic [31:0]];
  bit gnt_if = 0, gnt_dm = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    vectors++; errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: ack after a chosen number of extra BUSY cycles; a
  // latency of MW or more means the ack never comes.
  bit resp_active = 0; int rcnt, rlat;
  always @(negedge clk) begin
    if (rst) begin
      resp_active = 0; mem_ack = 0;
    end else begin
      if (mem_req && !resp_active) begin
        int r;
        resp_active = 1; rcnt = 0;
        r = $urandom_range(0, 19);
        if (force_lat >= 0) rlat = force_lat;
        else if (r < 8)     rlat = 0;
        else if (r < 16)    rlat = $urandom_range(1, 5);
        else if (r < 18)    rlat = MW - 1;
        else                rlat = MW;
        lat_q.push_back(rlat);
      end
      if (resp_active && mem_req) begin
        mem_ack = (rcnt == rlat);
        mem_rdata = mem_ack ? mem_f(mem_addr) : $urandom;
        rcnt++;
      end else begin
        resp_active = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard: models arbitration, latency, abort and rdata hold.
  bit in_flight = 0, owner = 0, last_data = 0, tmo_model = 0;
  bit prev_if = 0, prev_dm = 0;
  int start_cyc;
  req_t cur;
  logic [31:0] last_if_rd = '0, last_dm_rd = '0;
  always @(negedge clk) begin
    bit exp_ifd, exp_dmd, tmo, own;
    int n;
    logic [31:0] exp_rd;
    if (rst) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_done", {if_done, dm_done}, 0);
      chk("rst_timeout_err", timeout_err, 0);
      in_flight = 0; if_q.delete(); dm_q.delete(); lat_q.delete();
      tmo_model = 0; last_data = 0; gnt_if = 0; gnt_dm = 0;
      prev_if = 0; prev_dm = 0; last_if_rd = '0; last_dm_rd = '0;
    end else begin
      exp_ifd = 0; exp_dmd = 0;
      if (in_flight) begin
        if (lat_q.size() == 0) begin
          fail("latency_missing"); in_flight = 0;
        end else begin
          n = (lat_q[0] + 1 > MW) ? MW : lat_q[0] + 1;
          if (cyc >= start_cyc + n) begin
            tmo = (lat_q[0] >= MW);
            exp_rd = tmo ? 32'h0 : mem_f(cur.addr);
            if (owner) begin
              exp_dmd = 1; last_dm_rd = exp_rd;
              if (dm_q.size() > 0) void'(dm_q.pop_front());
            end else begin
              exp_ifd = 1; last_if_rd = exp_rd;
              if (if_q.size() > 0) void'(if_q.pop_front());
            end
            void'(lat_q.pop_front());
            chk("mem_req_resp", mem_req, 0);
            in_flight = 0; last_data = owner; tmo_model |= tmo;
            gnt_if = 0; gnt_dm = 0;
          end else begin
            chk("mem_req_busy", mem_req, 1);
            chk("mem_addr_hold", mem_addr, cur.addr);
            chk("mem_we_hold", mem_we, cur.we);
            if (owner) chk("mem_wdata_hold", mem_wdata, cur.wdata);
          end
        end
      end else if (mem_req) begin
        if (!(prev_if || prev_dm)) fail("grant_without_request");
        own = (prev_if && prev_dm) ? !last_data : prev_dm;
        if (own ? (dm_q.size() == 0) : (if_q.size() == 0)) fail("grant_owner_empty");
        else begin
          cur = own ? dm_q[0] : if_q[0];
          chk(own ? "grant_addr_data" : "grant_addr_fetch", mem_addr, cur.addr);
          chk("grant_we", mem_we, cur.we);
          if (own) chk("grant_wdata", mem_wdata, cur.wdata);
        end
        owner = own; in_flight = 1; start_cyc = cyc;
        if (own) gnt_dm = 1; else gnt_if = 1;
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
      chk("if_done", if_done, exp_ifd);
      chk("dm_done", dm_done, exp_dmd);
      chk("if_rdata", if_rdata, last_if_rd);
      chk("dm_rdata", dm_rdata, last_dm_rd);
      chk("timeout_err", timeout_err, tmo_model);
      chk("stall_if", stall_if, if_req & ~exp_ifd);
      chk("stall_mem", stall_mem, dm_req & ~exp_dmd);
      prev_if = if_req; prev_dm = dm_req;
    end
  end

  // One request held until its done pulse; inputs are scrambled once granted.
  task automatic do_req(input bit dm, input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
    req_t r;
    bit scr = 0, fin = 0;
    r.addr = a; r.we = dm ? we : 1'b0; r.wdata = dm ? wd : 32'h0;
    @(posedge clk); #2;
    if (dm) begin dm_q.push_back(r); dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1; end
    else    begin if_q.push_back(r); if_addr = a; if_req = 1; end
    for (int k = 0; k < 200 && !fin; k++) begin
      @(posedge clk); #1;
      if (dm ? dm_done : if_done) begin
        chk(dm ? "stall_mem_at_done" : "stall_if_at_done", dm ? stall_mem : stall_if, 0);
        #1;
        if (dm) dm_req = 0; else if_req = 0;
        fin = 1;
      end else begin
        #1;
        if (!scr && (dm ? gnt_dm : gnt_if)) begin
          scr = 1;
          if (dm) begin dm_addr ^= 32'h300; dm_wdata = ~dm_wdata; dm_we = ~dm_we; end
          else if_addr ^= 32'h300;
        end
      end
    end
    if (!fin) begin
      fail(dm ? "dm_done_missing" : "if_done_missing");
      if (dm) dm_req = 0; else if_req = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_img[32'h10] = 32'h0050_0093;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    force_lat = 0;  do_req(0, 0, 32'h10, 0);              // zero-wait fetch
    force_lat = 2;  do_req(1, 1, 32'h100, 32'hDEAD_BEEF); // 3-cycle store, addr changes to 0x200
    force_lat = 100; do_req(1, 0, 32'h180, 0);            // abort
    force_lat = MW - 1; do_req(0, 0, 32'h20, 0);          // ack in terminal cycle
    force_lat = 0;  do_req(1, 0, 32'h104, 0);             // normal after abort

    force_lat = 100;                                      // reset in the middle of BUSY
    @(posedge clk); #2;
    if_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    if_addr = 32'h40; if_req = 1;
    repeat (4) @(posedge clk); #2;
    rst = 1; #1;
    chk("rst_mid_busy_mem_req", mem_req, 0);
    if_req = 0;
    repeat (2) @(posedge clk); #2 rst = 0;

    force_lat = 0;                                        // continuous contention
    fork
      for (int i = 0; i < 4; i++) do_req(0, 0, 32'h1000 + 4 * i, 0);
      for (int i = 0; i < 4; i++) do_req(1, i[0], 32'h2000 + 4 * i, $urandom);
    join

    force_lat = -1;                                       // randomized traffic
    fork
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(0, 0, $urandom & 32'hFFFF_FFFC, 0);
      end
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(1, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom);
      end
    join
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
